// File: rtl/simt_reconv_stack_if.sv
// simt_reconv_stack_if
// Bundles the branch/sync request inputs and the mask/status outputs of the
// SIMT reconvergence controller.
//   master : the decode/control side; it drives the requests and reads the mask and status.
//   slave  : the reconvergence stack; it takes the requests and drives the mask and status.
// Requests : en, br_valid, br_taken, br_target_pc, br_fall_pc, sync_valid
// Status   : mask_o, redirect_o, redirect_pc_o, depth_o, empty_o, full_o,
//            overflow_o, proto_err_o
interface simt_reconv_stack_if #(
  parameter int THREADS = 4,
  parameter int DEPTH   = 8,
  parameter int PC_W    = 32
);
  localparam int DW = $clog2(DEPTH + 1);

  logic               en;
  logic               br_valid;
  logic [THREADS-1:0] br_taken;
  logic [PC_W-1:0]    br_target_pc;
  logic [PC_W-1:0]    br_fall_pc;
  logic               sync_valid;

  logic [THREADS-1:0] mask_o;
  logic               redirect_o;
  logic [PC_W-1:0]    redirect_pc_o;
  logic [DW-1:0]      depth_o;
  logic               empty_o;
  logic               full_o;
  logic               overflow_o;
  logic               proto_err_o;

  modport master (
    output en, br_valid, br_taken, br_target_pc, br_fall_pc, sync_valid,
    input  mask_o, redirect_o, redirect_pc_o, depth_o, empty_o, full_o,
           overflow_o, proto_err_o
  );

  modport slave (
    input  en, br_valid, br_taken, br_target_pc, br_fall_pc, sync_valid,
    output mask_o, redirect_o, redirect_pc_o, depth_o, empty_o, full_o,
           overflow_o, proto_err_o
  );
endinterface

// File: rtl/simt_reconv_stack.sv
// simt_reconv_stack
// Divergence and reconvergence controller for the SIMT datapath. It owns the
// active-thread mask. When a VBEQ/VBNE diverges, the controller pushes the
// not-taken path and runs the taken threads first. The first SYNC after that
// switches the mask to the pending threads. The second SYNC pops the entry and
// restores the saved mask. All outputs are registered.
// Ports:
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset; it discards the whole stack
//   sif : simt_reconv_stack_if.slave, which carries the requests in and the mask/status out
module simt_reconv_stack #(
  parameter int THREADS = 4,
  parameter int DEPTH   = 8,
  parameter int PC_W    = 32
) (
  input logic                CLK,
  input logic                RST,
  simt_reconv_stack_if.slave sif
);
  localparam int DW    = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] ONE      = DW'(1);
  localparam logic [DW-1:0] DEPTH_DW = DW'(DEPTH);

  logic [THREADS-1:0] full_mask_q [DEPTH];
  logic [THREADS-1:0] pend_mask_q [DEPTH];
  logic [PC_W-1:0]    pend_pc_q   [DEPTH];
  logic [DEPTH-1:0]   phase_q;
  logic [DEPTH-1:0]   valid_q;

  logic [THREADS-1:0] mask_q;
  logic               redirect_q;
  logic [PC_W-1:0]    redirect_pc_q;
  logic [DW-1:0]      depth_q;
  logic               empty_q;
  logic               full_q;
  logic               overflow_q;
  logic               proto_err_q;

  logic [THREADS-1:0] taken_m;
  logic [THREADS-1:0] not_taken_m;
  logic               stray_bits;
  logic [IDX_W-1:0]   top_idx;
  logic [IDX_W-1:0]   push_idx;

  always_comb begin
    taken_m     = sif.br_taken & mask_q;
    not_taken_m = mask_q & ~taken_m;
    stray_bits  = |(sif.br_taken & ~mask_q);
    top_idx     = IDX_W'(depth_q - ONE);
    // The push index fits because a push only happens when depth_q < DEPTH.
    push_idx    = IDX_W'(depth_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask_q        <= '1;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      depth_q       <= '0;
      empty_q       <= 1'b1;
      full_q        <= 1'b0;
      overflow_q    <= 1'b0;
      proto_err_q   <= 1'b0;
      phase_q       <= '0;
      valid_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        full_mask_q[i] <= '0;
        pend_mask_q[i] <= '0;
        pend_pc_q[i]   <= '0;
      end
    end else begin
      redirect_q <= 1'b0;
      if (sif.en) begin
        if (sif.br_valid && (sif.sync_valid || stray_bits))
          proto_err_q <= 1'b1;

        // When sync and branch arrive together, sync wins and the branch is dropped.
        if (sif.sync_valid) begin
          if (!empty_q && valid_q[top_idx]) begin
            if (!phase_q[top_idx]) begin
              mask_q           <= pend_mask_q[top_idx];
              redirect_q       <= 1'b1;
              redirect_pc_q    <= pend_pc_q[top_idx];
              phase_q[top_idx] <= 1'b1;
            end else begin
              // Execution falls through past SYNC, so there is no redirect here.
              mask_q           <= full_mask_q[top_idx];
              valid_q[top_idx] <= 1'b0;
              phase_q[top_idx] <= 1'b0;
              depth_q          <= depth_q - ONE;
              empty_q          <= (depth_q == ONE);
              full_q           <= 1'b0;
            end
          end
        end else if (sif.br_valid && (taken_m != '0)) begin
          if (taken_m == mask_q) begin
            redirect_q    <= 1'b1;
            redirect_pc_q <= sif.br_target_pc;
          end else if (full_q) begin
            overflow_q <= 1'b1;
          end else begin
            full_mask_q[push_idx] <= mask_q;
            pend_mask_q[push_idx] <= not_taken_m;
            pend_pc_q[push_idx]   <= sif.br_fall_pc;
            phase_q[push_idx]     <= 1'b0;
            valid_q[push_idx]     <= 1'b1;
            mask_q                <= taken_m;
            redirect_q            <= 1'b1;
            redirect_pc_q         <= sif.br_target_pc;
            depth_q               <= depth_q + ONE;
            empty_q               <= 1'b0;
            full_q                <= ((depth_q + ONE) == DEPTH_DW);
          end
        end
      end
    end
  end

  assign sif.mask_o        = mask_q;
  assign sif.redirect_o    = redirect_q;
  assign sif.redirect_pc_o = redirect_pc_q;
  assign sif.depth_o       = depth_q;
  assign sif.empty_o       = empty_q;
  assign sif.full_o        = full_q;
  assign sif.overflow_o    = overflow_q;
  assign sif.proto_err_o   = proto_err_q;
endmodule

// File: tb/tb_simt_reconv_stack.sv
// tb_simt_reconv_stack
// Directed bench for simt_reconv_stack with THREADS=4, DEPTH=2 and PC_W=32.
// Each test task drives requests through the interface and checks the registered
// outputs 1 time unit after the rising edge.
module tb_simt_reconv_stack;
  localparam int THREADS = 4;
  localparam int DEPTH   = 2;
  localparam int PC_W    = 32;

  logic CLK;
  logic RST;
  int   errors;
  int   checks;

  simt_reconv_stack_if #(.THREADS(THREADS), .DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  simt_reconv_stack #(.THREADS(THREADS), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .sif (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    bus.en           = 1'b1;
    bus.br_valid     = 1'b0;
    bus.br_taken     = '0;
    bus.br_target_pc = '0;
    bus.br_fall_pc   = '0;
    bus.sync_valid   = 1'b0;
  endtask

  // Apply one request for one clock edge, then return the inputs to idle.
  task automatic cycle(input logic en, input logic bv, input logic [3:0] tk,
                       input logic [31:0] tgt, input logic [31:0] fall, input logic sv);
    bus.en           = en;
    bus.br_valid     = bv;
    bus.br_taken     = tk;
    bus.br_target_pc = tgt;
    bus.br_fall_pc   = fall;
    bus.sync_valid   = sv;
    @(posedge CLK);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (bus.mask_o !== 4'b1111) begin errors++; $display("FAIL reset_mask got %b want 1111", bus.mask_o); end
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b want 0", bus.redirect_o); end
    checks++; if (bus.redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.redirect_pc_o); end
    checks++; if (bus.depth_o !== 2'd0) begin errors++; $display("FAIL reset_depth got %0d want 0", bus.depth_o); end
    checks++; if (bus.empty_o !== 1'b1 || bus.full_o !== 1'b0) begin errors++; $display("FAIL reset_empty_full got %b%b want 10", bus.empty_o, bus.full_o); end
    checks++; if (bus.overflow_o !== 1'b0 || bus.proto_err_o !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b%b want 00", bus.overflow_o, bus.proto_err_o); end
    #4 RST = 1'b0;
  endtask

  task automatic test_simple_divergence();
    cycle(1, 1, 4'b0011, 32'h100, 32'h40, 0);
    checks++; if (bus.mask_o !== 4'b0011) begin errors++; $display("FAIL div_mask got %b want 0011", bus.mask_o); end
    checks++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h100) begin errors++; $display("FAIL div_redirect got %b/%h want 1/100", bus.redirect_o, bus.redirect_pc_o); end
    checks++; if (bus.depth_o !== 2'd1 || bus.empty_o !== 1'b0) begin errors++; $display("FAIL div_depth got %0d/%b want 1/0", bus.depth_o, bus.empty_o); end
    cycle(1, 0, 4'b0000, 0, 0, 0);
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL div_pulse got %b want 0", bus.redirect_o); end
    cycle(1, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.mask_o !== 4'b1100) begin errors++; $display("FAIL sync1_mask got %b want 1100", bus.mask_o); end
    checks++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h40) begin errors++; $display("FAIL sync1_redirect got %b/%h want 1/40", bus.redirect_o, bus.redirect_pc_o); end
    checks++; if (bus.depth_o !== 2'd1) begin errors++; $display("FAIL sync1_depth got %0d want 1", bus.depth_o); end
    cycle(1, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.mask_o !== 4'b1111) begin errors++; $display("FAIL sync2_mask got %b want 1111", bus.mask_o); end
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL sync2_redirect got %b want 0", bus.redirect_o); end
    checks++; if (bus.depth_o !== 2'd0 || bus.empty_o !== 1'b1) begin errors++; $display("FAIL sync2_depth got %0d/%b want 0/1", bus.depth_o, bus.empty_o); end
  endtask

  task automatic test_uniform();
    cycle(1, 1, 4'b1111, 32'h200, 32'h204, 0);
    checks++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h200) begin errors++; $display("FAIL uni_taken_redirect got %b/%h want 1/200", bus.redirect_o, bus.redirect_pc_o); end
    checks++; if (bus.mask_o !== 4'b1111 || bus.depth_o !== 2'd0) begin errors++; $display("FAIL uni_taken_state got %b/%0d want 1111/0", bus.mask_o, bus.depth_o); end
    cycle(1, 1, 4'b0000, 32'h280, 32'h284, 0);
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL uni_not_redirect got %b want 0", bus.redirect_o); end
    checks++; if (bus.mask_o !== 4'b1111 || bus.depth_o !== 2'd0) begin errors++; $display("FAIL uni_not_state got %b/%0d want 1111/0", bus.mask_o, bus.depth_o); end
  endtask

  task automatic test_nest_overflow();
    cycle(1, 1, 4'b0111, 32'h300, 32'h304, 0);
    checks++; if (bus.mask_o !== 4'b0111 || bus.depth_o !== 2'd1 || bus.full_o !== 1'b0) begin errors++; $display("FAIL nest1 got %b/%0d/%b want 0111/1/0", bus.mask_o, bus.depth_o, bus.full_o); end
    cycle(1, 1, 4'b0011, 32'h400, 32'h404, 0);
    checks++; if (bus.mask_o !== 4'b0011 || bus.depth_o !== 2'd2 || bus.full_o !== 1'b1) begin errors++; $display("FAIL nest2 got %b/%0d/%b want 0011/2/1", bus.mask_o, bus.depth_o, bus.full_o); end
    checks++; if (bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h400) begin errors++; $display("FAIL nest2_redirect got %b/%h want 1/400", bus.redirect_o, bus.redirect_pc_o); end
    cycle(1, 1, 4'b0001, 32'h500, 32'h504, 0);
    checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.overflow_o); end
    checks++; if (bus.mask_o !== 4'b0011 || bus.depth_o !== 2'd2 || bus.redirect_o !== 1'b0) begin errors++; $display("FAIL ovf_state got %b/%0d/%b want 0011/2/0", bus.mask_o, bus.depth_o, bus.redirect_o); end
    cycle(1, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.mask_o !== 4'b0100 || bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h404) begin errors++; $display("FAIL nsync1 got %b/%b/%h want 0100/1/404", bus.mask_o, bus.redirect_o, bus.redirect_pc_o); end
    cycle(1, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.mask_o !== 4'b0111 || bus.redirect_o !== 1'b0 || bus.depth_o !== 2'd1 || bus.full_o !== 1'b0) begin errors++; $display("FAIL nsync2 got %b/%b/%0d/%b want 0111/0/1/0", bus.mask_o, bus.redirect_o, bus.depth_o, bus.full_o); end
    cycle(1, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.mask_o !== 4'b1000 || bus.redirect_o !== 1'b1 || bus.redirect_pc_o !== 32'h304) begin errors++; $display("FAIL nsync3 got %b/%b/%h want 1000/1/304", bus.mask_o, bus.redirect_o, bus.redirect_pc_o); end
    cycle(1, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.mask_o !== 4'b1111 || bus.redirect_o !== 1'b0 || bus.depth_o !== 2'd0 || bus.empty_o !== 1'b1) begin errors++; $display("FAIL nsync4 got %b/%b/%0d/%b want 1111/0/0/1", bus.mask_o, bus.redirect_o, bus.depth_o, bus.empty_o); end
    checks++; if (bus.overflow_o !== 1'b1 || bus.proto_err_o !== 1'b0) begin errors++; $display("FAIL nest_sticky got %b/%b want 1/0", bus.overflow_o, bus.proto_err_o); end
  endtask

  task automatic test_protocol_stall();
    cycle(1, 1, 4'b0011, 32'h600, 32'h604, 1);
    checks++; if (bus.proto_err_o !== 1'b1) begin errors++; $display("FAIL proto_both got %b want 1", bus.proto_err_o); end
    checks++; if (bus.mask_o !== 4'b1111 || bus.depth_o !== 2'd0 || bus.redirect_o !== 1'b0) begin errors++; $display("FAIL proto_state got %b/%0d/%b want 1111/0/0", bus.mask_o, bus.depth_o, bus.redirect_o); end
    cycle(0, 1, 4'b0101, 32'h700, 32'h704, 0);
    checks++; if (bus.mask_o !== 4'b1111 || bus.depth_o !== 2'd0 || bus.redirect_o !== 1'b0) begin errors++; $display("FAIL stall got %b/%0d/%b want 1111/0/0", bus.mask_o, bus.depth_o, bus.redirect_o); end
    cycle(1, 1, 4'b0101, 32'h700, 32'h704, 0);
    checks++; if (bus.mask_o !== 4'b0101 || bus.depth_o !== 2'd1 || bus.redirect_pc_o !== 32'h700 || bus.redirect_o !== 1'b1) begin errors++; $display("FAIL unstall got %b/%0d/%b/%h want 0101/1/1/700", bus.mask_o, bus.depth_o, bus.redirect_o, bus.redirect_pc_o); end
    cycle(0, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.mask_o !== 4'b0101 || bus.redirect_o !== 1'b0) begin errors++; $display("FAIL stall_sync got %b/%b want 0101/0", bus.mask_o, bus.redirect_o); end
    cycle(1, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.mask_o !== 4'b1010 || bus.redirect_pc_o !== 32'h704) begin errors++; $display("FAIL stall_sync1 got %b/%h want 1010/704", bus.mask_o, bus.redirect_pc_o); end
    cycle(1, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.mask_o !== 4'b1111 || bus.depth_o !== 2'd0) begin errors++; $display("FAIL stall_sync2 got %b/%0d want 1111/0", bus.mask_o, bus.depth_o); end
    checks++; if (bus.proto_err_o !== 1'b1) begin errors++; $display("FAIL proto_sticky got %b want 1", bus.proto_err_o); end
  endtask

  task automatic test_sync_empty();
    cycle(1, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.redirect_o !== 1'b0 || bus.mask_o !== 4'b1111 || bus.depth_o !== 2'd0 || bus.empty_o !== 1'b1) begin errors++; $display("FAIL sync_empty got %b/%b/%0d/%b want 0/1111/0/1", bus.redirect_o, bus.mask_o, bus.depth_o, bus.empty_o); end
  endtask

  task automatic test_async_reset();
    RST = 1'b1;
    #2;
    checks++; if (bus.proto_err_o !== 1'b0 || bus.overflow_o !== 1'b0) begin errors++; $display("FAIL rst_clear_sticky got %b/%b want 0/0", bus.proto_err_o, bus.overflow_o); end
    @(negedge CLK);
    RST = 1'b0;
    cycle(1, 1, 4'b0011, 32'h800, 32'h804, 0);
    // With the mask at 0011, taken 1110 leaves T=0010 and N=0001, and bits 3:2 are stray.
    cycle(1, 1, 4'b1110, 32'h900, 32'h904, 0);
    checks++; if (bus.mask_o !== 4'b0010 || bus.depth_o !== 2'd2 || bus.proto_err_o !== 1'b1) begin errors++; $display("FAIL stray_bits got %b/%0d/%b want 0010/2/1", bus.mask_o, bus.depth_o, bus.proto_err_o); end
    #2 RST = 1'b1;
    #1;
    checks++; if (bus.mask_o !== 4'b1111 || bus.depth_o !== 2'd0 || bus.empty_o !== 1'b1 || bus.redirect_o !== 1'b0) begin errors++; $display("FAIL async_rst got %b/%0d/%b/%b want 1111/0/1/0", bus.mask_o, bus.depth_o, bus.empty_o, bus.redirect_o); end
    checks++; if (bus.full_o !== 1'b0 || bus.proto_err_o !== 1'b0) begin errors++; $display("FAIL async_rst_flags got %b/%b want 0/0", bus.full_o, bus.proto_err_o); end
    @(negedge CLK);
    RST = 1'b0;
    cycle(1, 0, 4'b0000, 0, 0, 1);
    checks++; if (bus.mask_o !== 4'b1111 || bus.depth_o !== 2'd0 || bus.redirect_o !== 1'b0) begin errors++; $display("FAIL rst_stack_gone got %b/%0d/%b want 1111/0/0", bus.mask_o, bus.depth_o, bus.redirect_o); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_simple_divergence();
    test_uniform();
    test_nest_overflow();
    test_protocol_stall();
    test_sync_empty();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
